// File: rtl/ram_sync_ctrl.sv
// ram_sync_ctrl: clocked byte-addressed big-endian RAM behind a MOV/MOC
// handshake. Programmable access latency, signed/unsigned sub-word loads,
// and a two-beat doubleword transfer (second beat at latched address + 4).
module ram_sync_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  MOV,
  input  logic                  ReadWrite,
  input  logic [1:0]            DataType,
  input  logic                  Signed,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  MOC,
  output logic                  DwPending
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, DONE, DW_IDLE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [1:0]            dtype_q, dtype_d;
  logic                  sgn_q, sgn_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           dout_q, dout_d;
  logic                  moc_q, moc_d;
  logic                  dwp_q, dwp_d;

  logic [7:0]            mem [DEPTH];

  logic [ADDR_WIDTH-1:0] ba [4];
  logic [3:0][7:0]       rb;
  logic [3:0][7:0]       wb;
  logic [3:0]            be;
  logic [3:0]            wr_en;
  logic [31:0]           rd_fmt;
  logic                  do_acc;

  // Byte lane addresses (wrapping) and raw read bytes, lane 0 = first byte.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ba[k] = addr_q + ADDR_WIDTH'(k);
      rb[k] = mem[ba[k]];
    end
  end

  // Load formatting and store byte-lane mapping for the latched data type.
  always_comb begin
    wb     = '0;
    be     = 4'b0000;
    rd_fmt = '0;
    case (dtype_q)
      2'b00: begin
        be     = 4'b0001;
        wb[0]  = wdata_q[7:0];
        rd_fmt = {{24{sgn_q & rb[0][7]}}, rb[0]};
      end
      2'b01: begin
        be     = 4'b0011;
        wb[0]  = wdata_q[15:8];
        wb[1]  = wdata_q[7:0];
        rd_fmt = {{16{sgn_q & rb[0][7]}}, rb[0], rb[1]};
      end
      default: begin
        be     = 4'b1111;
        wb[0]  = wdata_q[31:24];
        wb[1]  = wdata_q[23:16];
        wb[2]  = wdata_q[15:8];
        wb[3]  = wdata_q[7:0];
        rd_fmt = {rb[0], rb[1], rb[2], rb[3]};
      end
    endcase
    wr_en = {4{do_acc & ~rw_q}} & be;
  end

  // Next-state logic. WAIT always runs WAIT_CYCLES+1 edges (counter down to
  // zero, then the access edge), so MOC rises WAIT_CYCLES+1 edges after the
  // edge that accepted MOV, including the zero-wait case.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    dtype_d = dtype_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    moc_d   = moc_q;
    dwp_d   = dwp_q;
    do_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MOV) begin
          addr_d  = Address;
          rw_d    = ReadWrite;
          dtype_d = DataType;
          sgn_d   = Signed;
          wdata_d = DataIn;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          do_acc  = 1'b1;
          moc_d   = 1'b1;
          state_d = DONE;
          if (rw_q) dout_d = rd_fmt;
          // set after doubleword beat 0, cleared after beat 1
          dwp_d   = (dtype_q == 2'b11) && !dwp_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (!MOV) begin
          moc_d   = 1'b0;
          state_d = dwp_q ? DW_IDLE : IDLE;
        end
      end
      DW_IDLE: begin
        // second beat reuses the latched type/direction; only data is new
        if (MOV) begin
          wdata_d = DataIn;
          addr_d  = addr_q + ADDR_WIDTH'(4);
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      dtype_q <= '0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
      moc_q   <= 1'b0;
      dwp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      dtype_q <= dtype_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      moc_q   <= moc_d;
      dwp_q   <= dwp_d;
    end
  end

  // Memory array: not cleared by reset; a reset edge suppresses the write.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_en[k]) mem[ba[k]] <= wb[k];
      end
    end
  end

  assign DataOut   = dout_q;
  assign MOC       = moc_q;
  assign DwPending = dwp_q;

endmodule

// File: tb/tb_ram_sync_ctrl.sv
// Scoreboard bench for ram_sync_ctrl: two instances (WAIT_CYCLES=2 and 0).
// Drivers push expected DataOut/latency; a negedge monitor pops on each MOC rise.
module tb_ram_sync_ctrl;

  localparam int WC [2] = '{2, 0};

  logic        clk = 1'b0;
  logic        rst;
  logic        mov [2];
  logic        rw  [2];
  logic        sg  [2];
  logic [1:0]  dt  [2];
  logic [7:0]  addr[2];
  logic [31:0] din [2];
  logic [31:0] dout[2];
  logic        moc [2];
  logic        dwp [2];

  always #5 clk = ~clk;

  ram_sync_ctrl #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut_w2 (
    .Clk(clk), .Reset(rst), .MOV(mov[0]), .ReadWrite(rw[0]), .DataType(dt[0]),
    .Signed(sg[0]), .Address(addr[0]), .DataIn(din[0]), .DataOut(dout[0]),
    .MOC(moc[0]), .DwPending(dwp[0]));

  ram_sync_ctrl #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut_w0 (
    .Clk(clk), .Reset(rst), .MOV(mov[1]), .ReadWrite(rw[1]), .DataType(dt[1]),
    .Signed(sg[1]), .Address(addr[1]), .DataIn(din[1]), .DataOut(dout[1]),
    .MOC(moc[1]), .DwPending(dwp[1]));

  typedef struct {
    logic [31:0] dout;
    int          issue;
    string       name;
  } exp_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] last_rd[2];
  int          npass = 0;
  int          ntot  = 0;
  int          cyc   = 0;
  logic        moc_prev[2];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Monitor: on every MOC rise, pop the oldest expectation and check
  // latency (edges since MOV was sampled) and DataOut.
  always @(negedge clk) begin
    exp_t e;
    logic got;
    for (int d = 0; d < 2; d++) begin
      if (moc[d] === 1'b1 && moc_prev[d] !== 1'b1) begin
        got = 1'b0;
        if (d == 0 && sb0.size() > 0) begin e = sb0.pop_front(); got = 1'b1; end
        if (d == 1 && sb1.size() > 0) begin e = sb1.pop_front(); got = 1'b1; end
        if (!got) begin
          ntot++;
          $display("FAIL unexpected_moc: dut %0d MOC rose with empty scoreboard at cycle %0d", d, cyc);
        end else begin
          chk({e.name, "_latency"}, 32'(cyc - e.issue), 32'(WC[d] + 1));
          chk({e.name, "_dout"}, dout[d], e.dout);
        end
      end
      moc_prev[d] = moc[d];
    end
  end

  task automatic wait_moc(input int d, input logic v, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (moc[d] !== v && n < 40);
    if (moc[d] !== v) begin
      ntot++;
      $display("FAIL %s_timeout: MOC=%b expected %b after %0d cycles", nm, moc[d], v, n);
    end
  endtask

  // Full handshake: raise MOV, scramble inputs while waiting, drop MOV on MOC.
  task automatic op(input int d, input bit r, input logic [1:0] t, input bit s,
                    input logic [7:0] a, input logic [31:0] data,
                    input logic [31:0] exp_rd, input string nm);
    exp_t e;
    @(negedge clk);
    mov[d] = 1'b1; rw[d] = r; dt[d] = t; sg[d] = s; addr[d] = a; din[d] = data;
    if (r) last_rd[d] = exp_rd;
    e.dout = last_rd[d]; e.issue = cyc + 1; e.name = nm;
    push(d, e);
    @(negedge clk);
    addr[d] = ~a; din[d] = ~data; dt[d] = ~t;
    wait_moc(d, 1'b1, nm);
    mov[d] = 1'b0;
    wait_moc(d, 1'b0, {nm, "_drop"});
  endtask

  // Read with MOV held for only the sampling edge: MOC must pulse one cycle.
  task automatic pulse(input int d, input logic [7:0] a, input logic [31:0] exp_rd,
                       input string nm);
    exp_t e;
    @(negedge clk);
    mov[d] = 1'b1; rw[d] = 1'b1; dt[d] = 2'b10; sg[d] = 1'b0; addr[d] = a;
    last_rd[d] = exp_rd;
    e.dout = exp_rd; e.issue = cyc + 1; e.name = nm;
    push(d, e);
    @(negedge clk);
    mov[d] = 1'b0;
    repeat (WC[d]) begin
      @(negedge clk);
      chk({nm, "_moc_wait"}, 32'(moc[d]), 32'd0);
    end
    @(negedge clk);
    chk({nm, "_moc_hi"}, 32'(moc[d]), 32'd1);
    @(negedge clk);
    chk({nm, "_moc_lo"}, 32'(moc[d]), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mov[d] = 0; rw[d] = 0; sg[d] = 0; dt[d] = 0; addr[d] = 0; din[d] = 0;
      last_rd[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_moc%0d", d), 32'(moc[d]), 32'd0);
      chk($sformatf("rst_dout%0d", d), dout[d], 32'd0);
      chk($sformatf("rst_dwp%0d", d), 32'(dwp[d]), 32'd0);
    end
    rst = 1'b0;

    // word store/load, byte layout big-endian
    op(0, 0, 2'b10, 0, 8'h10, 32'hDEADBEEF, 0, "st_w10");
    op(0, 1, 2'b10, 0, 8'h10, 0, 32'hDEADBEEF, "ld_w10");
    op(0, 1, 2'b00, 0, 8'h10, 0, 32'h000000DE, "ld_b10");
    op(0, 1, 2'b00, 0, 8'h13, 0, 32'h000000EF, "ld_b13");

    // signed / unsigned sub-word loads
    op(0, 0, 2'b00, 0, 8'h20, 32'h12345680, 0, "st_b20");
    op(0, 1, 2'b00, 0, 8'h20, 0, 32'h00000080, "ld_b20_u");
    op(0, 1, 2'b00, 1, 8'h20, 0, 32'hFFFFFF80, "ld_b20_s");
    op(0, 0, 2'b01, 0, 8'h22, 32'hAAAA8001, 0, "st_h22");
    op(0, 1, 2'b01, 1, 8'h22, 0, 32'hFFFF8001, "ld_h22_s");
    op(0, 1, 2'b01, 0, 8'h22, 0, 32'h00008001, "ld_h22_u");

    // doubleword store; beat-1 Address/DataType inputs must be ignored
    op(0, 0, 2'b00, 0, 8'h00, 32'h0000005A, 0, "st_b00");
    chk("dw_pend_before", 32'(dwp[0]), 32'd0);
    op(0, 0, 2'b11, 0, 8'h40, 32'h11223344, 0, "st_dw_b0");
    chk("dw_pend_between", 32'(dwp[0]), 32'd1);
    op(0, 0, 2'b00, 0, 8'h00, 32'h55667788, 0, "st_dw_b1");
    chk("dw_pend_after", 32'(dwp[0]), 32'd0);
    op(0, 1, 2'b10, 0, 8'h40, 0, 32'h11223344, "ld_w40");
    op(0, 1, 2'b10, 0, 8'h44, 0, 32'h55667788, "ld_w44");
    op(0, 1, 2'b00, 0, 8'h00, 0, 32'h0000005A, "ld_b00_untouched");
    op(0, 1, 2'b11, 0, 8'h40, 0, 32'h11223344, "ld_dw_b0");
    chk("dw_ld_pend_between", 32'(dwp[0]), 32'd1);
    op(0, 1, 2'b00, 1, 8'h00, 0, 32'h55667788, "ld_dw_b1");
    chk("dw_ld_pend_after", 32'(dwp[0]), 32'd0);

    // address wrap at top of memory
    op(0, 0, 2'b10, 0, 8'hFE, 32'hA1B2C3D4, 0, "st_wFE");
    op(0, 1, 2'b00, 0, 8'hFF, 0, 32'h000000B2, "ld_bFF");
    op(0, 1, 2'b00, 0, 8'h00, 0, 32'h000000C3, "ld_b00_wrap");
    op(0, 1, 2'b00, 0, 8'h01, 0, 32'h000000D4, "ld_b01_wrap");
    op(0, 1, 2'b10, 0, 8'hFE, 0, 32'hA1B2C3D4, "ld_wFE");

    // reset during WAIT of a word store aborts it
    op(0, 0, 2'b10, 0, 8'h30, 32'h01020304, 0, "st_w30");
    op(0, 1, 2'b10, 0, 8'h30, 0, 32'h01020304, "ld_w30_pre");
    @(negedge clk);
    mov[0] = 1'b1; rw[0] = 1'b0; dt[0] = 2'b10; addr[0] = 8'h30; din[0] = 32'hFFFFFFFF;
    @(negedge clk);
    mov[0] = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    chk("abort_moc", 32'(moc[0]), 32'd0);
    chk("abort_dout", dout[0], 32'd0);
    chk("abort_dwp", 32'(dwp[0]), 32'd0);
    op(0, 1, 2'b10, 0, 8'h30, 0, 32'h01020304, "ld_w30_post");

    // MOV dropped during WAIT: single-cycle MOC pulse
    pulse(0, 8'h10, 32'hDEADBEEF, "pulse_w2");

    // zero-wait instance
    op(1, 0, 2'b10, 0, 8'h10, 32'hCAFEF00D, 0, "w0_st_w10");
    op(1, 1, 2'b10, 0, 8'h10, 0, 32'hCAFEF00D, "w0_ld_w10");
    op(1, 1, 2'b00, 1, 8'h11, 0, 32'hFFFFFFFE, "w0_ld_b11_s");
    pulse(1, 8'h10, 32'hCAFEF00D, "pulse_w0");

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb0.size() + sb1.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
